// File: rtl/score_encoder.sv
// score_encoder: debounced button press counter driving a bar-graph score with a win latch.
// Defining SCORE_DECAY_EN adds idle-time score decay every DECAY_CYCLES cycles.
module score_encoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [5:0]  WIN_COUNT       = 6'd16,
    parameter logic [23:0] DECAY_CYCLES    = 24'd5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       clear,
    output logic [5:0] screen,
    output logic       press_pulse,
    output logic       win
);
    typedef enum logic [1:0] {RELEASED, PRESSED, WON} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic        db_q, db_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  screen_q, screen_d;
    logic        pulse_q, pulse_d;
    logic        accept;
    logic        lvl_diff, stable_done;

    assign lvl_diff    = s2_q != db_q;
    assign stable_done = lvl_diff && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
    assign cnt_d       = (lvl_diff && !stable_done) ? cnt_q + 16'd1 : '0;
    assign db_d        = stable_done ? s2_q : db_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= RELEASED;
            screen_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            screen_q <= screen_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef SCORE_DECAY_EN
    logic [23:0] dec_q, dec_d;

    always_ff @(posedge clk) begin
        if (reset) dec_q <= '0;
        else       dec_q <= dec_d;
    end
`else
    logic unused_decay;
    assign unused_decay = ^DECAY_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        screen_d = screen_q;
        pulse_d  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            RELEASED: if (db_q) begin
                accept   = 1'b1;
                pulse_d  = 1'b1;
                screen_d = (screen_q < WIN_COUNT) ? screen_q + 6'd1 : WIN_COUNT;
                state_d  = (screen_d == WIN_COUNT) ? WON : PRESSED;
            end
            PRESSED: if (!db_q) state_d = RELEASED;
            default: ;
        endcase
`ifdef SCORE_DECAY_EN
        dec_d = '0;
        if (state_q != WON && !accept) begin
            dec_d = dec_q + 24'd1;
            if (dec_q == DECAY_CYCLES - 24'd1) begin
                dec_d    = '0;
                screen_d = (screen_q != 6'd0) ? screen_q - 6'd1 : 6'd0;
            end
        end
`endif
        // clear overrides any same-edge press; a held button lands in PRESSED so it cannot rescore
        if (clear) begin
            screen_d = '0;
            pulse_d  = 1'b0;
            state_d  = db_q ? PRESSED : RELEASED;
`ifdef SCORE_DECAY_EN
            dec_d    = '0;
`endif
        end
    end

    assign screen      = screen_q;
    assign press_pulse = pulse_q;
    assign win         = state_q == WON;
endmodule
